// File: rtl/array_min_scanner_pkg.sv
// ============================================================================
// Module      : array_min_scanner_pkg
// Description : Shared state encoding and constants for the array-minimum scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package array_min_scanner_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FIRST   = 3'd1,
    SCAN    = 3'd2,
    WR_VAL  = 3'd3,
    WR_IDX  = 3'd4,
    WR_MAXV = 3'd5,
    WR_MAXI = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam int          WORD_BYTES       = 4;
  localparam logic [31:0] RES_ADDR_DEFAULT = 32'd2000;

endpackage

`default_nettype wire

// File: rtl/minmax_update.sv
// ============================================================================
// Module      : minmax_update
// Description : Registered signed compare-and-select of {value, index};
//               FIND_MAX selects greater-than instead of less-than.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module minmax_update #(
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 16,
  parameter bit FIND_MAX = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              update,
  input  logic [DATA_W-1:0] value,
  input  logic [IDX_W-1:0]  index,
  output logic [DATA_W-1:0] best_value,
  output logic [IDX_W-1:0]  best_index
);

  logic better;

  // Strict comparison so equal values keep the earliest index.
  always_comb begin
    better = 1'b0;
    if (FIND_MAX) better = $signed(value) > $signed(best_value);
    else          better = $signed(value) < $signed(best_value);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_value <= '0;
      best_index <= '0;
    end else if (load || (update && better)) begin
      best_value <= value;
      best_index <= index;
    end
  end

endmodule

`default_nettype wire

// File: rtl/array_min_scanner.sv
// ============================================================================
// Module      : array_min_scanner
// Description : Memory-initiator that scans COUNT signed words for the minimum
//               and writes {value, index} to RES_ADDR / RES_ADDR+4.
//               Define ARRAY_MIN_SCANNER_MAX_EN to also track the maximum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_min_scanner
  import array_min_scanner_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                CNT_W    = 16,
  parameter logic [ADDR_W-1:0] RES_ADDR = ADDR_W'(RES_ADDR_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_adr,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] mem_out,
  output logic [ADDR_W-1:0] inst_data_adr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mrd,
  output logic              mwr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] min_value,
  output logic [DATA_W-1:0] min_index
`ifdef ARRAY_MIN_SCANNER_MAX_EN
  ,
  output logic [DATA_W-1:0] max_value,
  output logic [DATA_W-1:0] max_index
`endif
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);
`ifdef ARRAY_MIN_SCANNER_MAX_EN
  localparam state_t LAST_WR = WR_MAXI;
`else
  localparam state_t LAST_WR = WR_IDX;
`endif

  state_t            state;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] adr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  i_cnt;
  logic [DATA_W-1:0] min_v;
  logic [CNT_W-1:0]  min_i;
  logic              load_first;
  logic              scan_upd;

  assign load_first = (state == FIRST);
  assign scan_upd   = (state == SCAN);

  // i_cnt is 0 in FIRST, so the first element is tagged with index 0.
  minmax_update #(.DATA_W(DATA_W), .IDX_W(CNT_W), .FIND_MAX(1'b0)) u_min (
    .clk(clk), .rst(rst), .load(load_first), .update(scan_upd),
    .value(mem_out), .index(i_cnt), .best_value(min_v), .best_index(min_i)
  );

`ifdef ARRAY_MIN_SCANNER_MAX_EN
  logic [DATA_W-1:0] max_v;
  logic [CNT_W-1:0]  max_i;

  minmax_update #(.DATA_W(DATA_W), .IDX_W(CNT_W), .FIND_MAX(1'b1)) u_max (
    .clk(clk), .rst(rst), .load(load_first), .update(scan_upd),
    .value(mem_out), .index(i_cnt), .best_value(max_v), .best_index(max_i)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      base_reg  <= '0;
      adr_reg   <= '0;
      cnt_reg   <= '0;
      i_cnt     <= '0;
      min_value <= '0;
      min_index <= '0;
`ifdef ARRAY_MIN_SCANNER_MAX_EN
      max_value <= '0;
      max_index <= '0;
`endif
    end else begin
      // Result outputs change only after a real scan, so count==0 keeps them.
      if (state == LAST_WR) begin
        min_value <= min_v;
        min_index <= {{(DATA_W-CNT_W){1'b0}}, min_i};
`ifdef ARRAY_MIN_SCANNER_MAX_EN
        max_value <= max_v;
        max_index <= {{(DATA_W-CNT_W){1'b0}}, max_i};
`endif
      end
      case (state)
        IDLE: begin
          if (start) begin
            base_reg <= base_adr;
            cnt_reg  <= count;
            i_cnt    <= '0;
            state    <= (count == '0) ? DONE : FIRST;
          end
        end
        FIRST: begin
          i_cnt   <= CNT_W'(1);
          adr_reg <= base_reg + STEP;
          state   <= (cnt_reg > CNT_W'(1)) ? SCAN : WR_VAL;
        end
        SCAN: begin
          i_cnt   <= i_cnt + CNT_W'(1);
          adr_reg <= adr_reg + STEP;
          if (i_cnt == cnt_reg - CNT_W'(1)) state <= WR_VAL;
        end
        WR_VAL:  state <= WR_IDX;
`ifdef ARRAY_MIN_SCANNER_MAX_EN
        WR_IDX:  state <= WR_MAXV;
        WR_MAXV: state <= WR_MAXI;
        WR_MAXI: state <= DONE;
`else
        WR_IDX:  state <= DONE;
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus signals are pure state decodes so reset removes them immediately.
  always_comb begin
    mrd           = 1'b0;
    mwr           = 1'b0;
    inst_data_adr = '0;
    mem_data_in   = '0;
    case (state)
      FIRST: begin
        mrd           = 1'b1;
        inst_data_adr = base_reg;
      end
      SCAN: begin
        mrd           = 1'b1;
        inst_data_adr = adr_reg;
      end
      WR_VAL: begin
        mwr           = 1'b1;
        inst_data_adr = RES_ADDR;
        mem_data_in   = min_v;
      end
      WR_IDX: begin
        mwr           = 1'b1;
        inst_data_adr = RES_ADDR + STEP;
        mem_data_in   = {{(DATA_W-CNT_W){1'b0}}, min_i};
      end
`ifdef ARRAY_MIN_SCANNER_MAX_EN
      WR_MAXV: begin
        mwr           = 1'b1;
        inst_data_adr = RES_ADDR + ADDR_W'(2 * WORD_BYTES);
        mem_data_in   = max_v;
      end
      WR_MAXI: begin
        mwr           = 1'b1;
        inst_data_adr = RES_ADDR + ADDR_W'(3 * WORD_BYTES);
        mem_data_in   = {{(DATA_W-CNT_W){1'b0}}, max_i};
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_array_min_scanner.sv
// ============================================================================
// Module      : tb_array_min_scanner
// Description : Directed self-checking bench for array_min_scanner with a
//               word-array memory model on the initiator port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_array_min_scanner;

`ifdef ARRAY_MIN_SCANNER_MAX_EN
  localparam int EXTRA = 6;
`else
  localparam int EXTRA = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_adr = '0;
  logic [15:0] count = '0;
  logic [31:0] mem_out;
  logic [31:0] inst_data_adr;
  logic [31:0] mem_data_in;
  logic        mrd, mwr, busy, done;
  logic [31:0] min_value, min_index;
`ifdef ARRAY_MIN_SCANNER_MAX_EN
  logic [31:0] max_value, max_index;
`endif

  logic [31:0] mem [0:1023];
  int checks = 0, passed = 0, fails = 0;
  int done_cnt = 0, rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  int lat;
  int arr_a [20] = '{12,13,21,31,44,53,19,2,-11,49,52,13,27,36,45,51,71,62,93,-84};

  always #5 clk = ~clk;

  array_min_scanner dut (
    .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .count(count),
    .mem_out(mem_out), .inst_data_adr(inst_data_adr), .mem_data_in(mem_data_in),
    .mrd(mrd), .mwr(mwr), .busy(busy), .done(done),
    .min_value(min_value), .min_index(min_index)
`ifdef ARRAY_MIN_SCANNER_MAX_EN
    , .max_value(max_value), .max_index(max_index)
`endif
  );

  assign mem_out = mrd ? mem[inst_data_adr[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (mwr) mem[inst_data_adr[11:2]] <= mem_data_in;
    if (done) done_cnt <= done_cnt + 1;
    if (mrd) rd_cnt <= rd_cnt + 1;
    if (mwr) wr_cnt <= wr_cnt + 1;
    if (mrd && mwr) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Start a scan; lat ends as the inclusive cycle count from start to done.
  // restart_at > 0 re-pulses start (with other operands) while busy.
  task automatic run(input logic [31:0] base, input logic [15:0] cnt, input int restart_at);
    base_adr = base;
    count    = cnt;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 2;
    while (!done && lat < 200) begin
      if (lat == restart_at) begin
        start = 1'b1; base_adr = 32'd1200; count = 16'd4;
      end else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic finish_run;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < 20; i++) mem[250 + i] = arr_a[i];

    // Reset state
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_mrd_mwr", {30'b0, mrd, mwr}, 32'd0);
    check("rst_min_value", min_value, 32'd0);
    check("rst_min_index", min_index, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 20-element array, minimum in last position
    done_cnt = 0;
    run(32'd1000, 16'd20, 0);
    check("a_latency", lat, 20 + EXTRA);
    check("a_min_value_out", min_value, -32'sd84);
    check("a_min_index_out", min_index, 32'd19);
    finish_run();
    check("a_mem2000", mem[500], -32'sd84);
    check("a_mem2004", mem[501], 32'd19);
    check("a_busy_after", {31'b0, busy}, 32'd0);
`ifdef ARRAY_MIN_SCANNER_MAX_EN
    check("a_mem2008", mem[502], 32'd93);
    check("a_mem2012", mem[503], 32'd18);
`endif

    // Last element changed to 5
    mem[269] = 32'd5;
    run(32'd1000, 16'd20, 0);
    check("b_latency", lat, 20 + EXTRA);
    finish_run();
    check("b_mem2000", mem[500], -32'sd11);
    check("b_mem2004", mem[501], 32'd8);
    check("b_min_index_out", min_index, 32'd8);
`ifdef ARRAY_MIN_SCANNER_MAX_EN
    check("b_mem2008", mem[502], 32'd93);
    check("b_mem2012", mem[503], 32'd18);
    check("b_max_value_out", max_value, 32'd93);
`endif

    // Ties keep earliest index
    mem[300] = 32'd7; mem[301] = 32'd3; mem[302] = 32'd3; mem[303] = 32'd3;
    run(32'd1200, 16'd4, 0);
    check("tie_latency", lat, 4 + EXTRA);
    finish_run();
    check("tie_mem2000", mem[500], 32'd3);
    check("tie_mem2004", mem[501], 32'd1);

    // Single element, most negative value
    mem[325] = 32'h8000_0000;
    run(32'd1300, 16'd1, 0);
    check("one_latency", lat, 1 + EXTRA);
    finish_run();
    check("one_mem2000", mem[500], 32'h8000_0000);
    check("one_mem2004", mem[501], 32'd0);
    check("one_min_value_out", min_value, 32'h8000_0000);

    // count==0: no bus traffic, outputs retained
    mem[500] = 32'h1234_5678;
    rd_cnt = 0; wr_cnt = 0;
    run(32'd1000, 16'd0, 0);
    check("zero_latency", lat, 2);
    finish_run();
    check("zero_rd_cnt", rd_cnt, 0);
    check("zero_wr_cnt", wr_cnt, 0);
    check("zero_mem2000", mem[500], 32'h1234_5678);
    check("zero_min_value_kept", min_value, 32'h8000_0000);

    // start during SCAN is ignored
    mem[269] = arr_a[19];
    done_cnt = 0;
    run(32'd1000, 16'd20, 6);
    check("restart_latency", lat, 20 + EXTRA);
    finish_run();
    repeat (5) @(posedge clk);
    #1;
    check("restart_done_cnt", done_cnt, 1);
    check("restart_mem2000", mem[500], -32'sd84);
    check("restart_mem2004", mem[501], 32'd19);

    // Asynchronous reset mid-SCAN
    mem[500] = 32'hDEAD_BEEF;
    base_adr = 32'd1000; count = 16'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("mid_scan_mrd_before", {31'b0, mrd}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_mrd_mwr", {30'b0, mrd, mwr}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("rst_mid_mem2000", mem[500], 32'hDEAD_BEEF);
    run(32'd1200, 16'd4, 0);
    check("post_rst_latency", lat, 4 + EXTRA);
    finish_run();
    check("post_rst_mem2000", mem[500], 32'd3);
    check("post_rst_mem2004", mem[501], 32'd1);

    check("never_rd_and_wr", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/array_min_scanner.md
Name: array_min_scanner

Overview:
- Memory-initiator accelerator that performs the array-minimum search in hardware, replacing the software loop on the multi-cycle MIPS.
- Drives the unified byte-addressed data memory over its interface: address, write data, read strobe, write strobe and read data.
- On start, it reads COUNT signed 32-bit words from base_adr. It tracks the minimum value and its index, writes both to RES_ADDR and RES_ADDR+4, then pulses done.
- Sits beside the CPU as a second memory master. Top-level muxing gives it the port while busy=1.

Parameters:
- DATA_W, 32, word width; fixed at 32.
- ADDR_W, 32, byte-address width.
- CNT_W, 16, width of element count.
- RES_ADDR, 2000, byte address of the result value word; the index word is at RES_ADDR+4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_adr  in  ADDR_W  byte address of element 0; word-aligned; latched on start.
- count  in  CNT_W  number of elements; latched on start.
- mem_out  in  DATA_W  memory read data; combinational, valid in the same cycle as mrd and inst_data_adr.
- inst_data_adr  out  ADDR_W  memory byte address.
- mem_data_in  out  DATA_W  memory write data.
- mrd  out  1  memory read strobe.
- mwr  out  1  memory write strobe; memory commits at posedge clk.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results are written.
- min_value  out  DATA_W  registered final minimum.
- min_index  out  DATA_W  registered final index, zero-extended.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs, min/index registers and the element counter clear to 0.
  - mrd and mwr drop immediately, so an in-flight write is abandoned.
- FSM states:
  - IDLE: start=1 latches base_adr and count, clears idx to 0, then:
    - count==0 -> DONE.
    - otherwise -> FIRST.
    - start while not in IDLE is ignored.
  - FIRST:
    - mrd=1, adr=base.
    - Capture min=mem_out, min_idx=0, i=1, adr_reg=base+4.
    - Next: SCAN if count>1, else WR_VAL.
  - SCAN:
    - mrd=1, adr=adr_reg.
    - If $signed(mem_out) < $signed(min): min<=mem_out, min_idx<=i. Strict less-than, so ties keep the earliest index.
    - i<=i+1, adr_reg<=adr_reg+4.
    - Go to WR_VAL when i==count-1.
  - WR_VAL: mwr=1, adr=RES_ADDR, mem_data_in=min.
  - WR_IDX: mwr=1, adr=RES_ADDR+4, mem_data_in=min_idx.
  - DONE:
    - done=1 for one cycle.
    - min_value and min_index outputs update.
    - Next state is IDLE.
- Strobe rules:
  - mrd and mwr are Moore decodes of state; never both high.
  - In non-memory states, adr and mem_data_in are 0.
- count==0:
  - No memory traffic at all.
  - done pulses 2 cycles after start.
  - min_value and min_index stay at their previous values.
- Latency from start to done for count=N≥1: N+4 cycles (IDLE accept, N reads, 2 writes, DONE).
- busy=1 in every state except IDLE.
- Address arithmetic is modulo 2^ADDR_W; wrap is not flagged.
- Width: i and min_idx are CNT_W bits internally and are zero-extended on output.

Optional Feature:
- Macro: ARRAY_MIN_SCANNER_MAX_EN.
- When defined:
  - Also tracks the signed maximum and its index; strict greater-than, so ties keep the earliest index.
  - Adds states WR_MAXV (RES_ADDR+8) and WR_MAXI (RES_ADDR+12) after WR_IDX.
  - Adds output ports max_value and max_index.
  - Latency becomes N+6.
- When undefined: no max logic, no extra ports or states.

Decomposition:
- Package array_min_scanner_pkg holds:
  - state enum: IDLE, FIRST, SCAN, WR_VAL, WR_IDX, WR_MAXV, WR_MAXI, DONE;
  - WORD_BYTES=4;
  - default RES_ADDR.
- One sub-module, minmax_update: a registered signed compare-and-select of {value, index}. It is instantiated once, or twice with polarity set when ARRAY_MIN_SCANNER_MAX_EN is defined.

Test Plan:
- 20-word array at 1000 = {12,13,21,31,44,53,19,2,-11,49,52,13,27,36,45,51,71,62,93,-84}, count=20 -> mem[2000]=-84, mem[2004]=19, done exactly 24 cycles after start.
- Same array with the last element changed to 5 -> min=-11, idx=8. With MAX_EN defined: mem[2008]=93, mem[2012]=18.
- Ties: array {7,3,3,3}, count=4 -> min=3, idx=1.
- count=1 with word 0x80000000 -> min=0x80000000, idx=0, 5-cycle latency. count=0 -> no mrd/mwr ever asserted, done 2 cycles after start.
- start pulsed again during SCAN -> ignored, results unchanged, exactly one done pulse.
- rst low mid-SCAN -> mrd/mwr/busy drop the same cycle, mem[2000] is not written, and a fresh start afterwards completes correctly.
